cpu_trace_monitor: RTL and testbench
====================================

CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
REQ-001 SHALL have parameters: ADDR_W=32, byte-address width of PC and data address; DATA_W=32, instruction/data width; DEPTH=16, trace entries, power of 2, >=2; NUM_BP=2, PC breakpoints, 1..8; TS_W=16, timestamp width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: retire_valid in 1 instruction retired this cycle; retire_pc in ADDR_W; retire_instr in DATA_W.
REQ-004 SHALL have ports: rf_we in 1; rf_waddr in 4; rf_wdata in DATA_W; mem_we in 1; mem_addr in ADDR_W; mem_wdata in DATA_W (all qualify the retiring instruction).
REQ-005 SHALL have ports: cfg_enable in 1; cfg_mode in 1 (0 = wrap, 1 = stop-when-full); cfg_clear in 1 pulse; bp_en in NUM_BP; bp_addr in NUM_BP*ADDR_W; resume in 1 pulse.
REQ-006 SHALL have ports: rd_req in 1; rd_valid out 1; rd_pc out ADDR_W; rd_instr out DATA_W; rd_kind out 2 (bit0 = rf_we, bit1 = mem_we); rd_data out DATA_W; rd_ts out TS_W.
REQ-007 SHALL have ports: halt out 1 CPU stall request; count out $clog2(DEPTH)+1 valid entries; overflow out 1 sticky; state out 2.

Function
REQ-008 SHALL use FSM states IDLE=0, RUN=1, HALTED=2, FULL=3.
REQ-009 IDLE -> RUN when cfg_enable=1; any state -> IDLE when cfg_enable=0 (priority below reset, above all else).
REQ-010 In RUN, each cycle with retire_valid=1 SHALL push one entry {pc, instr, kind, data, ts}; data = rf_wdata if rf_we, else mem_wdata if mem_we, else 0.
REQ-011 Breakpoint: in RUN, retire_valid=1 and retire_pc == bp_addr[i] with bp_en[i]=1 for any i SHALL push the entry and go HALTED next cycle.
REQ-012 HALTED: halt=1 combinationally from state; retire_valid ignored; resume=1 -> RUN next cycle; the first retire after resume is exempt from the breakpoint match.
REQ-013 Wrap mode, buffer full, push: oldest entry overwritten, read pointer advances, count stays DEPTH, overflow set.
REQ-014 Stop mode: a push that makes count == DEPTH SHALL move RUN -> FULL; FULL captures nothing; leaves to RUN the cycle after a pop.
REQ-015 Breakpoint and full on the same push: HALTED wins; the full condition is re-evaluated on resume.
REQ-016 Read: rd_req=1 and count>0 SHALL pop the oldest entry, presented on rd_* with rd_valid=1 the next cycle (latency 1); rd_req with count=0 SHALL give rd_valid=0 and change nothing.
REQ-017 Simultaneous push and pop: the pop returns the pre-push oldest entry; count unchanged; in wrap mode at full, overflow is not set (no loss).
REQ-018 rd_* SHALL hold the last popped values while rd_valid=0.
REQ-019 The timestamp counter SHALL increment every cycle in RUN or FULL, hold in IDLE/HALTED, and wrap modulo 2^TS_W.
REQ-020 cfg_clear SHALL zero pointers, count, overflow and timestamp next cycle without changing state; a push in the same cycle is discarded.
REQ-021 Reads SHALL be permitted in every state.

Reset
REQ-022 rst=0 SHALL asynchronously force state=IDLE, halt=0, count=0, overflow=0, rd_valid=0, rd_* = 0, timestamp=0, pointers=0; buffer contents need not be reset.

Structure
REQ-023 Package trace_pkg SHALL hold the state enum, kind encoding and the packed entry struct (parameterised via a type parameter or width localparams).
REQ-024 Circular storage and pointers SHALL be a sub-module trace_fifo (push, pop, overwrite_en, count, full, empty); FSM, breakpoint compare and timestamp live in cpu_trace_monitor.

Verification
REQ-025 Enable, retire pc 0,4,8 with rf_we, rf_wdata 5,6,7; then 3 rd_req -> rd_pc 0,4,8, rd_data 5,6,7, rd_kind 01, ts strictly increasing, count back to 0.
REQ-026 bp_en=01, bp_addr[0]=0x10; retire 0x0C, 0x10 -> halt=1 from the cycle after 0x10, count=2; resume, retire 0x10 -> no halt, count=3.
REQ-027 DEPTH=16, wrap mode, 20 retires pc=4*k -> count=16, overflow=1, first pop rd_pc=0x10.
REQ-028 Stop mode, 17 retires -> state=FULL after 16th, 17th not stored; one pop -> rd_pc=0, state RUN next cycle.
REQ-029 Wrap mode at full, push and pop in same cycle -> popped oldest returned, count=16, overflow stays 0.
REQ-030 Assert rst=0 mid-halt between clock edges -> halt=0, state=IDLE immediately; cfg_clear with 5 entries -> count=0, overflow=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the CPU trace monitor: FSM states, entry kind bits and the
// trace entry layout at the default widths.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FULL   = 2'd3
    } state_e;

    localparam logic [1:0] KIND_RF  = 2'b01;
    localparam logic [1:0] KIND_MEM = 2'b10;

    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_TS_W   = 16;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] pc;
        logic [ENTRY_DATA_W-1:0] instr;
        logic [1:0]              kind;
        logic [ENTRY_DATA_W-1:0] data;
        logic [ENTRY_TS_W-1:0]   ts;
    } trace_entry_t;

    function automatic logic [1:0] kind_of(input logic rf_we, input logic mem_we);
        return (rf_we ? KIND_RF : 2'b00) | (mem_we ? KIND_MEM : 2'b00);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace storage with optional overwrite-oldest when full.
// Head entry is visible combinationally on rdata_o.
module trace_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   overwrite_en_i,
    input  T                       wdata_i,
    output T                       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overwrite_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                mem_q [DEPTH];
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_pop, do_write, ovw;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // A pop in the same cycle frees a slot, so a push at full only loses data without one.
    assign do_pop      = pop_i && !empty_o && !clear_i;
    assign ovw         = push_i && !clear_i && full_o && !do_pop && overwrite_en_i;
    assign do_write    = push_i && !clear_i && (!full_o || do_pop || overwrite_en_i);
    assign overwrite_o = ovw;
    assign rdata_o     = mem_q[rd_q];
    assign count_o     = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_write)
                wr_d = wr_q + 1'b1;
            if (do_pop || ovw)
                rd_d = rd_q + 1'b1;
            if (do_write && !do_pop && !ovw)
                cnt_d = cnt_q + 1'b1;
            else if (do_pop && !do_write)
                cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Retirement trace monitor: captures retired instructions with their writeback
// data and a timestamp, supports PC breakpoints that stall the CPU.
module cpu_trace_monitor
    import trace_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_BP = 2,
    parameter int TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     retire_valid,
    input  logic [ADDR_W-1:0]        retire_pc,
    input  logic [DATA_W-1:0]        retire_instr,
    input  logic                     rf_we,
    input  logic [3:0]               rf_waddr,
    input  logic [DATA_W-1:0]        rf_wdata,
    input  logic                     mem_we,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic                     cfg_enable,
    input  logic                     cfg_mode,
    input  logic                     cfg_clear,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic                     resume,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [DATA_W-1:0]        rd_instr,
    output logic [1:0]               rd_kind,
    output logic [DATA_W-1:0]        rd_data,
    output logic [TS_W-1:0]          rd_ts,
    output logic                     halt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               state
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [1:0]        kind;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } entry_t;

    state_e            state_q;
    logic [TS_W-1:0]   ts_q;
    logic              ovf_q;
    logic              skip_q;
    logic              rd_valid_q;
    entry_t            rd_q;

    entry_t            wr_entry, head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, fifo_ovw;
    logic              bp_match, push, pop, bp_hit, becomes_full, stuck_full, ts_run;
    logic              unused_ok;

    assign unused_ok = ^{rf_waddr, mem_addr};

    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++)
            if (bp_en[i] && retire_pc == bp_addr[i*ADDR_W +: ADDR_W])
                bp_match = 1'b1;
    end

    always_comb begin
        wr_entry.pc    = retire_pc;
        wr_entry.instr = retire_instr;
        wr_entry.kind  = kind_of(rf_we, mem_we);
        wr_entry.data  = rf_we ? rf_wdata : (mem_we ? mem_wdata : '0);
        wr_entry.ts    = ts_q;
    end

    // In stop mode a push at full is refused unless a pop makes room this cycle.
    assign pop          = rd_req && !fifo_empty && !cfg_clear;
    assign push         = (state_q == ST_RUN) && retire_valid && cfg_enable && !cfg_clear
                          && !(cfg_mode && fifo_full && !pop);
    assign bp_hit       = push && bp_match && !skip_q;
    assign becomes_full = push && !pop && (fifo_count == CNT_W'(DEPTH - 1));
    assign stuck_full   = fifo_full && !pop && !cfg_clear;
    assign ts_run       = (state_q == ST_RUN) || (state_q == ST_FULL);

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst),
        .clear_i        (cfg_clear),
        .push_i         (push),
        .pop_i          (pop),
        .overwrite_en_i (!cfg_mode),
        .wdata_i        (wr_entry),
        .rdata_o        (head),
        .count_o        (fifo_count),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .overwrite_o    (fifo_ovw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            ovf_q      <= 1'b0;
            skip_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            rd_valid_q <= pop;
            if (pop)
                rd_q <= head;

            if (cfg_clear) begin
                ts_q  <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (ts_run)
                    ts_q <= ts_q + 1'b1;
                if (fifo_ovw)
                    ovf_q <= 1'b1;
            end

            if (!cfg_enable) begin
                state_q <= ST_IDLE;
                skip_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE:   state_q <= ST_RUN;
                    ST_RUN: begin
                        if (retire_valid)
                            skip_q <= 1'b0;
                        if (bp_hit)
                            state_q <= ST_HALTED;
                        else if (cfg_mode && (becomes_full || stuck_full))
                            state_q <= ST_FULL;
                    end
                    // The retire right after resume is exempt from re-triggering the breakpoint.
                    ST_HALTED: begin
                        if (resume) begin
                            skip_q  <= 1'b1;
                            state_q <= (cfg_mode && stuck_full) ? ST_FULL : ST_RUN;
                        end
                    end
                    ST_FULL: begin
                        if (pop || !cfg_mode || !fifo_full)
                            state_q <= ST_RUN;
                    end
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign halt     = (state_q == ST_HALTED);
    assign state    = state_q;
    assign count    = fifo_count;
    assign overflow = ovf_q;
    assign rd_valid = rd_valid_q;
    assign rd_pc    = rd_q.pc;
    assign rd_instr = rd_q.instr;
    assign rd_kind  = rd_q.kind;
    assign rd_data  = rd_q.data;
    assign rd_ts    = rd_q.ts;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Scoreboard bench for cpu_trace_monitor at default parameters.
module tb_cpu_trace_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire_valid, rf_we, mem_we;
    logic [31:0] retire_pc, retire_instr, rf_wdata, mem_addr, mem_wdata;
    logic [3:0]  rf_waddr;
    logic        cfg_enable, cfg_mode, cfg_clear, resume, rd_req;
    logic [1:0]  bp_en;
    logic [63:0] bp_addr;
    logic        rd_valid, halt, overflow;
    logic [31:0] rd_pc, rd_instr, rd_data;
    logic [1:0]  rd_kind, state;
    logic [15:0] rd_ts;
    logic [4:0]  count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic [1:0]  kind;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] ts_seen[$];
    int          n_chk = 0;
    int          n_err = 0;

    cpu_trace_monitor dut (
        .clk(clk), .rst(rst),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_clear(cfg_clear),
        .bp_en(bp_en), .bp_addr(bp_addr), .resume(resume), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_kind(rd_kind),
        .rd_data(rd_data), .rd_ts(rd_ts), .halt(halt), .count(count),
        .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input exp_t e, input bit with_pop);
        if (with_pop || sb.size() < 16)
            sb.push_back(e);
        else if (!cfg_mode) begin
            void'(sb.pop_front());
            sb.push_back(e);
        end
    endtask

    task automatic do_retire(input logic [31:0] pc, input logic rf, input logic mem,
                             input logic [31:0] d, input bit store, input bit with_pop);
        exp_t e;
        retire_valid = 1'b1;
        retire_pc    = pc;
        retire_instr = 32'hA500_0000 ^ pc;
        rf_we        = rf;
        mem_we       = mem;
        rf_waddr     = pc[5:2];
        mem_addr     = pc + 32'h1000;
        rf_wdata     = rf  ? d : 32'hDEAD_0001;
        mem_wdata    = mem ? d : 32'hDEAD_0002;
        rd_req       = with_pop;
        e.pc    = pc;
        e.instr = 32'hA500_0000 ^ pc;
        e.data  = (rf || mem) ? d : 32'h0;
        e.kind  = {mem, rf};
        if (store)
            model_push(e, with_pop);
        tick();
        retire_valid = 1'b0;
        rf_we        = 1'b0;
        mem_we       = 1'b0;
        rd_req       = 1'b0;
    endtask

    task automatic do_read;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic do_clear;
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (rst && rd_valid) begin
            if (sb.size() == 0)
                chk("rd_spurious", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("rd_pc",    rd_pc,    mon_e.pc);
                chk("rd_instr", rd_instr, mon_e.instr);
                chk("rd_data",  rd_data,  mon_e.data);
                chk("rd_kind",  rd_kind,  mon_e.kind);
                ts_seen.push_back(rd_ts);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        {retire_valid, rf_we, mem_we, cfg_enable, cfg_mode, cfg_clear, resume, rd_req} = '0;
        {retire_pc, retire_instr, rf_wdata, mem_addr, mem_wdata} = '0;
        rf_waddr = '0;
        bp_en    = '0;
        bp_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_halt", halt, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdpc", rd_pc, 0);
        rst = 1'b1;
        cfg_enable = 1'b1;
        tick();
        chk("en_run", state, 1);

        // Basic capture and readback
        for (int k = 0; k < 3; k++)
            do_retire(32'(4 * k), 1'b1, 1'b0, 32'(5 + k), 1'b1, 1'b0);
        chk("basic_cnt3", count, 3);
        ts_seen.delete();
        repeat (3) do_read();
        tick();
        chk("basic_cnt0", count, 0);
        chk("ts_n", ts_seen.size(), 3);
        if (ts_seen.size() == 3) begin
            chk("ts_inc1", 16'(ts_seen[1] - ts_seen[0]), 1);
            chk("ts_inc2", 16'(ts_seen[2] - ts_seen[1]), 1);
        end
        do_retire(32'h20, 1'b0, 1'b1, 32'h99, 1'b1, 1'b0);
        do_retire(32'h24, 1'b0, 1'b0, 32'h55, 1'b1, 1'b0);
        do_retire(32'h28, 1'b1, 1'b1, 32'h77, 1'b1, 1'b0);
        repeat (3) do_read();
        tick();

        // Breakpoints on both slots, resume exemption
        do_clear();
        chk("clr_cnt", count, 0);
        bp_en   = 2'b01;
        bp_addr = {32'hFFFF_FFF0, 32'h0000_0010};
        do_retire(32'h0C, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
        do_retire(32'h10, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0);
        chk("bp_halt", halt, 1);
        chk("bp_state", state, 2);
        chk("bp_cnt", count, 2);
        do_retire(32'h30, 1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
        chk("halt_ignore", count, 2);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_run", state, 1);
        chk("resume_halt", halt, 0);
        do_retire(32'h10, 1'b1, 1'b0, 32'h4, 1'b1, 1'b0);
        chk("exempt_halt", halt, 0);
        chk("exempt_cnt", count, 3);
        bp_en   = 2'b10;
        bp_addr = {32'h0000_0040, 32'h0000_0010};
        do_retire(32'h40, 1'b0, 1'b1, 32'h5, 1'b1, 1'b0);
        chk("bp1_halt", halt, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        bp_en = 2'b00;
        repeat (4) do_read();
        tick();

        // Wrap mode overflow
        do_clear();
        for (int k = 0; k < 20; k++)
            do_retire(32'(4 * k), 1'b1, 1'b0, 32'(k), 1'b1, 1'b0);
        chk("wrap_cnt", count, 16);
        chk("wrap_ovf", overflow, 1);
        do_read();
        chk("wrap_first", rd_pc, 32'h10);
        repeat (15) do_read();
        tick();
        chk("wrap_drain", count, 0);
        chk("ovf_sticky", overflow, 1);
        do_clear();
        chk("clr_ovf", overflow, 0);

        // Stop-when-full
        cfg_mode = 1'b1;
        do_clear();
        for (int k = 0; k < 16; k++)
            do_retire(32'(4 * k), 1'b1, 1'b0, 32'(k + 100), 1'b1, 1'b0);
        chk("stop_full", state, 3);
        do_retire(32'h40, 1'b1, 1'b0, 32'hBAD, 1'b1, 1'b0);
        chk("stop_cnt", count, 16);
        do_read();
        chk("stop_pc0", rd_pc, 0);
        chk("stop_run", state, 1);
        repeat (15) do_read();
        tick();

        // Wrap at full with simultaneous push and pop
        cfg_mode = 1'b0;
        do_clear();
        for (int k = 0; k < 16; k++)
            do_retire(32'h100 + 32'(4 * k), 1'b1, 1'b0, 32'(k + 200), 1'b1, 1'b0);
        do_retire(32'h200, 1'b1, 1'b0, 32'h300, 1'b1, 1'b1);
        chk("pp_pc", rd_pc, 32'h100);
        chk("pp_cnt", count, 16);
        chk("pp_ovf", overflow, 0);
        repeat (16) do_read();
        tick();

        // Async reset mid-halt, then clear
        do_clear();
        bp_en   = 2'b01;
        bp_addr = {32'h0000_0040, 32'h0000_0050};
        for (int k = 0; k < 4; k++)
            do_retire(32'h44 + 32'(4 * k), 1'b1, 1'b0, 32'(k), 1'b1, 1'b0);
        chk("pre_rst_halt", halt, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_halt", halt, 0);
        chk("arst_state", state, 0);
        chk("arst_cnt", count, 0);
        chk("arst_rdpc", rd_pc, 0);
        sb.delete();
        rst = 1'b1;
        bp_en = 2'b00;
        tick();
        chk("post_rst_run", state, 1);
        for (int k = 0; k < 5; k++)
            do_retire(32'h60 + 32'(4 * k), 1'b1, 1'b0, 32'(k), 1'b1, 1'b0);
        chk("five_cnt", count, 5);
        cfg_clear = 1'b1;
        do_retire(32'h90, 1'b1, 1'b0, 32'h9, 1'b0, 1'b0);
        cfg_clear = 1'b0;
        sb.delete();
        chk("clr5_cnt", count, 0);
        chk("clr5_ovf", overflow, 0);
        chk("clr5_state", state, 1);
        do_retire(32'h70, 1'b1, 1'b0, 32'h11, 1'b1, 1'b0);
        do_read();
        tick();
        if (ts_seen.size() > 0)
            chk("clr_ts", ts_seen[$], 0);
        do_read();
        chk("empty_rdv", rd_valid, 0);
        chk("empty_hold", rd_pc, 32'h70);
        cfg_enable = 1'b0;
        tick();
        chk("dis_idle", state, 0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
